rca_error_monitor: RTL and testbench

//  Response-side checker for the ripple-carry / approximate adders: consumes operand+result samples

---
 rtl/rca_error_monitor_pkg.sv | 14 +
 rtl/rca_error_distance.sv | 24 ++
 rtl/rca_error_monitor.sv | 130 +++++++++++++
 tb/tb_rca_error_monitor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_error_monitor_pkg.sv
// rtl/rca_error_monitor_pkg.sv - shared state encoding and defaults for the adder error monitor
package rca_error_monitor_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/rca_error_distance.sv
// rtl/rca_error_distance.sv - combinational error distance between exact and approximate adder results
module rca_error_distance
    import rca_error_monitor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic [WIDTH:0]   ed,
    output logic             err
);

    logic [WIDTH:0] exact;
    logic [WIDTH:0] approx;

    assign exact  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign approx = {cout, sum};
    assign ed     = (exact >= approx) ? (exact - approx) : (approx - exact);
    assign err    = (exact != approx);

endmodule

// File: rtl/rca_error_monitor.sv
// rtl/rca_error_monitor.sv - windowed error-metric accumulator for adders under test
module rca_error_monitor
    import rca_error_monitor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        n_samples,
    input  logic                    valid_in,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic                    cin,
    input  logic [WIDTH-1:0]        sum,
    input  logic                    cout,
    output logic                    busy,
    output logic                    done,
    output logic                    mismatch,
    output logic [CNT_W-1:0]        sample_cnt,
    output logic [CNT_W-1:0]        err_cnt,
    output logic [WIDTH:0]          max_ed,
    output logic [CNT_W+WIDTH:0]    sum_ed
);

    localparam int SUM_W = CNT_W + WIDTH + 1;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   n_lat;
    logic               accept;
    logic               last_sample;
    logic               pipe_empty;

    logic               s1_valid;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [WIDTH-1:0]   s1_sum;
    logic               s1_cin;
    logic               s1_cout;
    logic [WIDTH:0]     s1_ed;
    logic               s1_err;

    logic               s2_valid;
    logic [WIDTH:0]     s2_ed;
    logic               s2_err;

    logic [SUM_W:0]     sum_ext;

    rca_error_distance #(.WIDTH(WIDTH)) u_dist (
        .a    (s1_a),
        .b    (s1_b),
        .cin  (s1_cin),
        .sum  (s1_sum),
        .cout (s1_cout),
        .ed   (s1_ed),
        .err  (s1_err)
    );

    assign accept      = (state == ST_RUN) && valid_in;
    assign last_sample = ((sample_cnt + CNT_W'(1)) == n_lat);
    assign pipe_empty  = !s1_valid && !s2_valid;
    assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
    assign done        = (state == ST_FIN);
    assign mismatch    = s2_valid && s2_err;
    // One extra bit catches overflow so the running sum can clamp at all-ones
    assign sum_ext     = {1'b0, sum_ed} + {{(SUM_W - WIDTH){1'b0}}, s2_ed};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = (n_samples == '0) ? ST_FIN : ST_RUN;
            ST_RUN:   if (accept && last_sample) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pipe_empty) state_nxt = ST_FIN;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            n_lat      <= '0;
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_sum     <= '0;
            s1_cin     <= 1'b0;
            s1_cout    <= 1'b0;
            s2_valid   <= 1'b0;
            s2_ed      <= '0;
            s2_err     <= 1'b0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            max_ed     <= '0;
            sum_ed     <= '0;
        end else begin
            state    <= state_nxt;
            s1_valid <= accept;
            if (accept) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_cin  <= cin;
                s1_sum  <= sum;
                s1_cout <= cout;
            end
            s2_valid <= s1_valid;
            s2_ed    <= s1_ed;
            s2_err   <= s1_err;

            // The pipeline is always empty in IDLE, so clearing here cannot drop a sample
            if (state == ST_IDLE && start) begin
                n_lat      <= n_samples;
                sample_cnt <= '0;
                err_cnt    <= '0;
                max_ed     <= '0;
                sum_ed     <= '0;
            end else begin
                if (accept) sample_cnt <= sample_cnt + CNT_W'(1);
                if (s2_valid) begin
                    if (s2_err) err_cnt <= err_cnt + CNT_W'(1);
                    if (s2_ed > max_ed) max_ed <= s2_ed;
                    sum_ed <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rca_error_monitor.sv
// tb/tb_rca_error_monitor.sv - scoreboard bench for rca_error_monitor with directed vectors
module tb_rca_error_monitor;

    localparam int WIDTH = 4;
    localparam int CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [CNT_W-1:0]     n_samples;
    logic                 valid_in;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 cin;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic                 busy;
    logic                 done;
    logic                 mismatch;
    logic [CNT_W-1:0]     sample_cnt;
    logic [CNT_W-1:0]     err_cnt;
    logic [WIDTH:0]       max_ed;
    logic [CNT_W+WIDTH:0] sum_ed;

    rca_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_samples  (n_samples),
        .valid_in   (valid_in),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .sum        (sum),
        .cout       (cout),
        .busy       (busy),
        .done       (done),
        .mismatch   (mismatch),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt),
        .max_ed     (max_ed),
        .sum_ed     (sum_ed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int scnt;
        int ecnt;
        int maxed;
        int sumed;
    } win_t;

    win_t done_q[$];
    int   mm_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic put(input logic [3:0] av, input logic [3:0] bv, input logic ci,
                       input logic [3:0] sv, input logic co, input bit acc, input bit err);
        a = av; b = bv; cin = ci; sum = sv; cout = co; valid_in = 1'b1;
        if (acc) begin
            last_cyc = cyc;
            if (err) mm_q.push_back(cyc + 2);
        end
        tick();
        valid_in = 1'b0;
    endtask

    task automatic start_win(input int n);
        n_samples = n[CNT_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_done(input int scnt, input int ecnt, input int maxed, input int sumed);
        done_q.push_back('{last_cyc + 4, scnt, ecnt, maxed, sumed});
    endtask

    task automatic check_metrics(input string tag, input int scnt, input int ecnt,
                                 input int maxed, input int sumed, input int bsy);
        check({tag, "_sample_cnt"}, sample_cnt, scnt);
        check({tag, "_err_cnt"}, err_cnt, ecnt);
        check({tag, "_max_ed"}, max_ed, maxed);
        check({tag, "_sum_ed"}, sum_ed, sumed);
        check({tag, "_busy"}, busy, bsy);
    endtask

    // Monitor: every mismatch/done pulse is matched against the scoreboard queues
    always @(negedge clk) begin
        if (mismatch === 1'b1) begin
            if (mm_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_mismatch: pulse at cycle %0d, none expected", cyc);
            end else begin
                check("mismatch_cycle", cyc, mm_q.pop_front());
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: pulse at cycle %0d, none expected", cyc);
            end else begin
                win_t w;
                w = done_q.pop_front();
                check("done_cycle", cyc, w.cyc);
                check("done_sample_cnt", sample_cnt, w.scnt);
                check("done_err_cnt", err_cnt, w.ecnt);
                check("done_max_ed", max_ed, w.maxed);
                check("done_sum_ed", sum_ed, w.sumed);
                check("done_busy", busy, 0);
                check("done_mismatch_pending", mm_q.size(), 0);
            end
        end
    end

    initial begin
        int s;
        rst = 1'b1; start = 1'b0; valid_in = 1'b0; n_samples = '0;
        a = '0; b = '0; cin = 1'b0; sum = '0; cout = 1'b0;
        idle(3);
        @(negedge clk);
        check("rst_done", done, 0);
        check("rst_mismatch", mismatch, 0);
        check_metrics("rst", 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();

        // Reset in the middle of a window: no DONE, everything back to zero
        start_win(5);
        put(4'd3, 4'd12, 1'b0, 4'd15, 1'b0, 1, 0);
        put(4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1, 0);
        put(4'd5, 4'd5, 1'b0, 4'd10, 1'b0, 1, 0);
        @(negedge clk);
        check("pre_rst_sample_cnt", sample_cnt, 3);
        check("pre_rst_busy", busy, 1);
        tick();
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        check("midrst_done", done, 0);
        check_metrics("midrst", 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        idle(8);
        @(negedge clk);
        check_metrics("post_rst", 0, 0, 0, 0, 0);
        tick();

        // Exact sums only
        start_win(3);
        put(4'd3, 4'd12, 1'b0, 4'd15, 1'b0, 1, 0);
        put(4'd11, 4'd12, 1'b1, 4'd8, 1'b1, 1, 0);
        put(4'd3, 4'd4, 1'b1, 4'd8, 1'b0, 1, 0);
        expect_done(3, 0, 0, 0);
        idle(8);

        // Two erroneous samples, ED 1 and ED 31
        start_win(2);
        put(4'd11, 4'd12, 1'b1, 4'd9, 1'b1, 1, 1);
        put(4'd15, 4'd15, 1'b1, 4'd0, 1'b0, 1, 1);
        expect_done(2, 2, 31, 32);
        idle(8);

        // VALID_IN held for 6 cycles, only the first 4 belong to the window
        start_win(4);
        put(4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1, 0);
        put(4'd2, 4'd2, 1'b0, 4'd5, 1'b0, 1, 1);
        put(4'd7, 4'd7, 1'b0, 4'd14, 1'b0, 1, 0);
        put(4'd8, 4'd8, 1'b0, 4'd0, 1'b0, 1, 1);
        put(4'd15, 4'd15, 1'b1, 4'd0, 1'b0, 0, 0);
        put(4'd0, 4'd0, 1'b0, 4'd1, 1'b0, 0, 0);
        expect_done(4, 2, 16, 17);
        idle(8);

        // Empty window: DONE right after START, never busy, metrics cleared
        s = cyc;
        done_q.push_back('{s + 1, 0, 0, 0, 0});
        start_win(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("n0_busy", busy, 0);
            tick();
        end
        idle(4);

        // START+VALID in IDLE, START while RUN/DRAIN/FIN, VALID in FIN/IDLE: all ignored
        n_samples = 16'd2;
        start = 1'b1;
        put(4'd15, 4'd15, 1'b1, 4'd0, 1'b0, 0, 0);
        n_samples = 16'd1;
        start = 1'b1;
        put(4'd11, 4'd12, 1'b1, 4'd9, 1'b1, 1, 1);
        start = 1'b0;
        tick();
        put(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1, 0);
        expect_done(2, 1, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        idle(2);
        n_samples = 16'd3;
        start = 1'b1;
        put(4'd15, 4'd15, 1'b1, 4'd0, 1'b0, 0, 0);
        start = 1'b0;
        put(4'd15, 4'd15, 1'b1, 4'd0, 1'b0, 0, 0);
        put(4'd2, 4'd2, 1'b0, 4'd5, 1'b0, 0, 0);
        idle(6);
        @(negedge clk);
        check_metrics("ignored", 2, 1, 1, 1, 0);
        tick();

        idle(8);
        check("done_q_left", done_q.size(), 0);
        check("mm_q_left", mm_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
